// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   Raster timing source for the VGA path. It divides the system clock into a
//   pixel enable, runs the horizontal/vertical position counters and decodes
//   HSYNC, VSYNC, the visible-area flag and an end-of-frame pulse. The default
//   parameters give 640x480 @ 60 Hz (800x525 total) from a 100 MHz clock.
//
//   H_TOTAL (sum of H_*) and V_TOTAL (sum of V_*) must each be <= 1024.
//   CLK_DIV is legal from 1 to 16. With CLK_DIV = 1 no divider is built and
//   o_p_tick is held high.
//
// Ports
//   i_clk        in   system clock, all logic on the rising edge
//   i_reset      in   asynchronous, active-high reset
//   o_p_tick     out  pixel enable, high one i_clk cycle in every CLK_DIV
//   o_x          out  horizontal count, 0..H_TOTAL-1
//   o_y          out  vertical count, 0..V_TOTAL-1
//   o_hsync      out  horizontal sync, active level = SYNC_POL
//   o_vsync      out  vertical sync, active level = SYNC_POL
//   o_video_on   out  high inside the visible area
//   o_frame_tick out  one-cycle pulse on the last pixel tick of a frame
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic       o_p_tick,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_video_on,
    output logic       o_frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Sync windows, inclusive bounds.
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // Visible limits compared at 11 bits so a 1024-wide display still works.
    localparam logic [10:0] H_VIS = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS = 11'(V_DISPLAY);

    logic       p_tick;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;

    // -----------------------------------------------------------------------
    // Pixel-clock divider
    // -----------------------------------------------------------------------
    if (CLK_DIV == 1) begin : g_no_div
        assign p_tick = 1'b1;
    end else begin : g_div
        localparam int DIV_W = $clog2(CLK_DIV);
        localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

        logic [DIV_W-1:0] div_q, div_d;

        always_comb begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block ordering.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                div_q <= '0;
            end else begin
                div_q <= div_d;
            end
        end

        // Tick on the last divider state, so the first pixel advance after
        // reset release comes exactly CLK_DIV edges later.
        assign p_tick = (div_q == DIV_LAST);
    end

    // -----------------------------------------------------------------------
    // Position counters
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: hold-value defaults first, so no path leaves x_d/y_d
        // unassigned and no latch is inferred.
        x_d = x_q;
        y_d = y_q;
        if (p_tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode: purely combinational from the counters so sync and
    // blanking line up cycle-exactly with o_x/o_y.
    // -----------------------------------------------------------------------
    logic h_active;
    logic v_active;

    assign h_active = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    assign v_active = (y_q >= VS_FIRST) && (y_q <= VS_LAST);

    assign o_p_tick     = p_tick;
    assign o_x          = x_q;
    assign o_y          = y_q;
    assign o_hsync      = h_active ? SYNC_POL : ~SYNC_POL;
    assign o_vsync      = v_active ? SYNC_POL : ~SYNC_POL;
    assign o_video_on   = ({1'b0, x_q} < H_VIS) && ({1'b0, y_q} < V_VIS);
    assign o_frame_tick = p_tick && (x_q == H_LAST) && (y_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Three instances share one clock and reset:
//     u_def  - default 640x480 timing, CLK_DIV=4, active-low sync
//     u_sml  - tiny raster (15x10), CLK_DIV=3, active-low sync
//     u_fst  - tiny raster (9x7),   CLK_DIV=1, active-high sync
//   The reference model works from the number of rising edges n since reset
//   release: pixel index k = n / D, x = k mod H_TOTAL, y = (k / H_TOTAL) mod
//   V_TOTAL, tick when n mod D = D-1. Reset state equals the model at n = 0.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

    typedef struct packed {
        int d;
        int hd, hf, hs, hb;
        int vd, vf, vs, vb;
        bit pol;
    } cfg_t;

    localparam cfg_t C_DEF = '{d: 4, hd: 640, hf: 16, hs: 96, hb: 48,
                               vd: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0};
    localparam cfg_t C_SML = '{d: 3, hd: 8, hf: 2, hs: 3, hb: 2,
                               vd: 6, vf: 1, vs: 2, vb: 1, pol: 1'b0};
    localparam cfg_t C_FST = '{d: 1, hd: 5, hf: 1, hs: 2, hb: 1,
                               vd: 4, vf: 1, vs: 1, vb: 1, pol: 1'b1};

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic       d_tick, d_hs, d_vs, d_von, d_ft;
    logic [9:0] d_x, d_y;
    logic       s_tick, s_hs, s_vs, s_von, s_ft;
    logic [9:0] s_x, s_y;
    logic       f_tick, f_hs, f_vs, f_von, f_ft;
    logic [9:0] f_x, f_y;

    vga_sync_gen #(
        .CLK_DIV(C_DEF.d), .H_DISPLAY(C_DEF.hd), .H_FRONT(C_DEF.hf),
        .H_SYNC(C_DEF.hs), .H_BACK(C_DEF.hb), .V_DISPLAY(C_DEF.vd),
        .V_FRONT(C_DEF.vf), .V_SYNC(C_DEF.vs), .V_BACK(C_DEF.vb),
        .SYNC_POL(C_DEF.pol)
    ) u_def (
        .i_clk(clk), .i_reset(rst), .o_p_tick(d_tick), .o_x(d_x), .o_y(d_y),
        .o_hsync(d_hs), .o_vsync(d_vs), .o_video_on(d_von), .o_frame_tick(d_ft)
    );

    vga_sync_gen #(
        .CLK_DIV(C_SML.d), .H_DISPLAY(C_SML.hd), .H_FRONT(C_SML.hf),
        .H_SYNC(C_SML.hs), .H_BACK(C_SML.hb), .V_DISPLAY(C_SML.vd),
        .V_FRONT(C_SML.vf), .V_SYNC(C_SML.vs), .V_BACK(C_SML.vb),
        .SYNC_POL(C_SML.pol)
    ) u_sml (
        .i_clk(clk), .i_reset(rst), .o_p_tick(s_tick), .o_x(s_x), .o_y(s_y),
        .o_hsync(s_hs), .o_vsync(s_vs), .o_video_on(s_von), .o_frame_tick(s_ft)
    );

    vga_sync_gen #(
        .CLK_DIV(C_FST.d), .H_DISPLAY(C_FST.hd), .H_FRONT(C_FST.hf),
        .H_SYNC(C_FST.hs), .H_BACK(C_FST.hb), .V_DISPLAY(C_FST.vd),
        .V_FRONT(C_FST.vf), .V_SYNC(C_FST.vs), .V_BACK(C_FST.vb),
        .SYNC_POL(C_FST.pol)
    ) u_fst (
        .i_clk(clk), .i_reset(rst), .o_p_tick(f_tick), .o_x(f_x), .o_y(f_y),
        .o_hsync(f_hs), .o_vsync(f_vs), .o_video_on(f_von), .o_frame_tick(f_ft)
    );

    int checks = 0;
    int errors = 0;
    int n      = 0;   // rising edges since reset release
    int d_hs_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s n=%0d observed %0d expected %0d", tag, n, obs, expv);
        end
    endtask

    task automatic check_cfg(input string name, input cfg_t c, input int edges,
                             input logic tick, input logic [9:0] x, input logic [9:0] y,
                             input logic hs, input logic vs, input logic von, input logic ft);
        int  ht, vt, k, ex, ey;
        bit  etick, ehs, evs, evon, eft;
        ht    = c.hd + c.hf + c.hs + c.hb;
        vt    = c.vd + c.vf + c.vs + c.vb;
        k     = edges / c.d;
        ex    = k % ht;
        ey    = (k / ht) % vt;
        etick = (edges % c.d) == (c.d - 1);
        ehs   = (ex >= c.hd + c.hf && ex < c.hd + c.hf + c.hs) ? c.pol : !c.pol;
        evs   = (ey >= c.vd + c.vf && ey < c.vd + c.vf + c.vs) ? c.pol : !c.pol;
        evon  = (ex < c.hd) && (ey < c.vd);
        eft   = etick && (ex == ht - 1) && (ey == vt - 1);
        check({name, " p_tick"},     32'(tick), 32'(etick));
        check({name, " x"},          32'(x),    32'(ex));
        check({name, " y"},          32'(y),    32'(ey));
        check({name, " hsync"},      32'(hs),   32'(ehs));
        check({name, " vsync"},      32'(vs),   32'(evs));
        check({name, " video_on"},   32'(von),  32'(evon));
        check({name, " frame_tick"}, 32'(ft),   32'(eft));
    endtask

    task automatic check_all(input int edges);
        check_cfg("def", C_DEF, edges, d_tick, d_x, d_y, d_hs, d_vs, d_von, d_ft);
        check_cfg("sml", C_SML, edges, s_tick, s_x, s_y, s_hs, s_vs, s_von, s_ft);
        check_cfg("fst", C_FST, edges, f_tick, f_x, f_y, f_hs, f_vs, f_von, f_ft);
    endtask

    // Advance len cycles, checking every instance on each falling edge.
    task automatic run(input int len);
        repeat (len) begin
            @(negedge clk);
            n++;
            check_all(n);
            if (d_hs === C_DEF.pol) d_hs_cycles++;
        end
    endtask

    // Assert reset asynchronously inside a clock phase, check at once, then
    // release on a falling edge.
    task automatic async_reset();
        if ($urandom_range(0, 1) == 1) @(posedge clk);
        else                           @(negedge clk);
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        n = 0;
        check_all(0);
        @(negedge clk);
        check_all(0);
        rst = 1'b0;
        n = 0;
        #1;
        check_all(0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all(0);

        rst = 1'b0;
        n   = 0;
        #1;
        check_all(0);

        // Long first run: covers a full default line (hsync window and the
        // 799 -> 0 wrap with y stepping) and several tiny frames.
        run(3300);
        check("def hsync active cycles per line", 32'(d_hs_cycles), 32'(C_DEF.hs * C_DEF.d));

        // Random mid-frame resets with random run lengths.
        for (int e = 0; e < 8; e++) begin
            async_reset();
            run($urandom_range(20, 700));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
